// File: rtl/arm_pipelined_mul_sequencer.sv
// Shift-and-add MUL/MLA sequencer that borrows the execute-stage ALU (ADD only).
// Latency: k MUL cycles (k = highest set bit of B + 1, min 1), plus 1 ACC cycle for MLA, plus 1 DONE cycle.
// Backpressure: none; o_Busy stalls the pipeline and i_Start is ignored unless IDLE (no queueing).
module arm_pipelined_mul_sequencer #(
    parameter int BusWidth = 32
) (
    input  logic                i_CLK,
    input  logic                i_NRESET,
    input  logic                i_Start,
    input  logic                i_Accumulate,
    input  logic [BusWidth-1:0] i_Op_A,
    input  logic [BusWidth-1:0] i_Op_B,
    input  logic [BusWidth-1:0] i_Op_C,
    output logic                o_Busy,
    output logic                o_Done,
    output logic [BusWidth-1:0] o_Result,
    output logic [3:0]          o_Flags,
    output logic                o_ALU_Req,
    output logic [BusWidth-1:0] o_ALU_A,
    output logic [BusWidth-1:0] o_ALU_B,
    output logic [1:0]          o_ALU_Control,
    input  logic [BusWidth-1:0] i_ALU_Out
);

    localparam int CW = (BusWidth > 1) ? $clog2(BusWidth) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_ACC  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t              r_state;
    logic [BusWidth-1:0] r_p;
    logic [BusWidth-1:0] r_d;
    logic [BusWidth-1:0] r_m;
    logic [BusWidth-1:0] r_c;
    logic                r_acc;
    logic [CW-1:0]       r_count;
    logic                r_busy;
    logic                r_done;
    logic                r_req;
    logic [BusWidth-1:0] r_result;
    logic [3:0]          r_flags;

    logic [BusWidth-1:0] w_m_next;
    logic [BusWidth-1:0] w_p_step;
    logic [BusWidth-1:0] w_p_final;
    logic                w_last;

    // Per-iteration datapath: add D only when the current multiplier bit is set;
    // the loop ends once no set multiplier bits remain or all bits are consumed.
    assign w_m_next  = r_m >> 1;
    assign w_p_step  = r_m[0] ? i_ALU_Out : r_p;
    assign w_last    = (w_m_next == '0) || (r_count == CW'(BusWidth - 1));
    // Value that lands in the result register on the edge entering DONE.
    assign w_p_final = (r_state == S_ACC) ? i_ALU_Out : w_p_step;

    // Control FSM with registered status outputs, datapath registers and result capture.
    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            r_state  <= S_IDLE;
            r_p      <= '0;
            r_d      <= '0;
            r_m      <= '0;
            r_c      <= '0;
            r_acc    <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_req    <= 1'b0;
            r_result <= '0;
            r_flags  <= 4'b0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_Start) begin
                        r_d     <= i_Op_A;
                        r_m     <= i_Op_B;
                        r_c     <= i_Op_C;
                        r_acc   <= i_Accumulate;
                        r_p     <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_req   <= 1'b1;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_p     <= w_p_step;
                    r_d     <= r_d << 1;
                    r_m     <= w_m_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        if (r_acc) begin
                            r_state <= S_ACC;
                        end else begin
                            r_state  <= S_DONE;
                            r_req    <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_p_final;
                            r_flags  <= {w_p_final[BusWidth-1], (w_p_final == '0), 2'b00};
                        end
                    end
                end
                S_ACC: begin
                    r_p      <= i_ALU_Out;
                    r_state  <= S_DONE;
                    r_req    <= 1'b0;
                    r_done   <= 1'b1;
                    r_result <= w_p_final;
                    r_flags  <= {w_p_final[BusWidth-1], (w_p_final == '0), 2'b00};
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ALU operand steering: accumulate with D during MUL, add the addend during ACC, idle at zero.
    always_comb begin
        o_ALU_A = '0;
        o_ALU_B = '0;
        case (r_state)
            S_MUL: begin
                o_ALU_A = r_p;
                o_ALU_B = r_d;
            end
            S_ACC: begin
                o_ALU_A = r_p;
                o_ALU_B = r_c;
            end
            default: begin
                o_ALU_A = '0;
                o_ALU_B = '0;
            end
        endcase
    end

    assign o_ALU_Control = 2'b00;
    assign o_Busy        = r_busy;
    assign o_Done        = r_done;
    assign o_ALU_Req     = r_req;
    assign o_Result      = r_result;
    assign o_Flags       = r_flags;

endmodule

// File: tb/tb_arm_pipelined_mul_sequencer.sv
// Scoreboard bench for the MUL/MLA sequencer with a behavioural ALU on the loop-back path.
// Latency: expectations carry the start edge and predicted cycle counts.
// Backpressure: stimulus waits for o_Busy low (bounded) before issuing.
module tb_arm_pipelined_mul_sequencer;

    localparam int W = 32;

    logic         i_CLK = 1'b0;
    logic         i_NRESET;
    logic         i_Start;
    logic         i_Accumulate;
    logic [W-1:0] i_Op_A;
    logic [W-1:0] i_Op_B;
    logic [W-1:0] i_Op_C;
    logic         o_Busy;
    logic         o_Done;
    logic [W-1:0] o_Result;
    logic [3:0]   o_Flags;
    logic         o_ALU_Req;
    logic [W-1:0] o_ALU_A;
    logic [W-1:0] o_ALU_B;
    logic [1:0]   o_ALU_Control;
    logic [W-1:0] i_ALU_Out;

    arm_pipelined_mul_sequencer #(.BusWidth(W)) dut (
        .i_CLK         (i_CLK),
        .i_NRESET      (i_NRESET),
        .i_Start       (i_Start),
        .i_Accumulate  (i_Accumulate),
        .i_Op_A        (i_Op_A),
        .i_Op_B        (i_Op_B),
        .i_Op_C        (i_Op_C),
        .o_Busy        (o_Busy),
        .o_Done        (o_Done),
        .o_Result      (o_Result),
        .o_Flags       (o_Flags),
        .o_ALU_Req     (o_ALU_Req),
        .o_ALU_A       (o_ALU_A),
        .o_ALU_B       (o_ALU_B),
        .o_ALU_Control (o_ALU_Control),
        .i_ALU_Out     (i_ALU_Out)
    );

    always #5 i_CLK = ~i_CLK;

    // Execute-stage ALU: ADD/SUB/AND/ORR.
    always_comb begin
        i_ALU_Out = '0;
        case (o_ALU_Control)
            2'b00: i_ALU_Out = o_ALU_A + o_ALU_B;
            2'b01: i_ALU_Out = o_ALU_A - o_ALU_B;
            2'b10: i_ALU_Out = o_ALU_A & o_ALU_B;
            default: i_ALU_Out = o_ALU_A | o_ALU_B;
        endcase
    end

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flags;
        int           k;
        int           acc;
        int           e0;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   req_cnt = 0;

    always @(posedge i_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Number of multiplier bits that must be walked: position of top set bit + 1, at least 1.
    function automatic int bits_of(input logic [W-1:0] b);
        int k = 1;
        for (int i = 0; i < W; i++)
            if (b[i]) k = i + 1;
        return k;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] c, input bit acc, input int e0);
        exp_t e;
        logic [2*W-1:0] full;
        full    = a * b;
        e.res   = full[W-1:0] + (acc ? c : '0);
        e.flags = {e.res[W-1], (e.res == 0) ? 1'b1 : 1'b0, 2'b00};
        e.k     = bits_of(b);
        e.acc   = acc ? 1 : 0;
        e.e0    = e0;
        return e;
    endfunction

    // Monitor: pops one expectation per o_Done and checks result, flags and timing.
    always @(negedge i_CLK) begin
        exp_t e;
        if (!i_NRESET) begin
            busy_cnt = 0;
            req_cnt  = 0;
        end else begin
            if (o_Busy) busy_cnt++;
            if (o_ALU_Req) req_cnt++;
            if (o_Done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: o_Done with no outstanding op, result 0x%0h, expected none", o_Result);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'(o_Result), 64'(e.res));
                    check("flags", 64'(o_Flags), 64'(e.flags));
                    check("done_cycle", 64'(cyc), 64'(e.e0 + e.k + e.acc));
                    check("alu_req_cycles", 64'(req_cnt), 64'(e.k + e.acc));
                    check("busy_cycles", 64'(busy_cnt), 64'(e.k + e.acc + 1));
                    check("alu_control", 64'(o_ALU_Control), 64'(0));
                end
                busy_cnt = 0;
                req_cnt  = 0;
            end
        end
    end

    // Issue one operation at the first negedge where the sequencer is idle; called at a negedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input bit acc);
        int guard = 0;
        while (o_Busy && guard < 300) begin
            @(negedge i_CLK);
            guard++;
        end
        if (o_Busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: o_Busy=%0b after %0d cycles, required 0", o_Busy, guard);
            return;
        end
        i_Op_A       = a;
        i_Op_B       = b;
        i_Op_C       = c;
        i_Accumulate = acc;
        i_Start      = 1'b1;
        sb.push_back(model(a, b, c, acc, cyc + 1));
        @(negedge i_CLK);
        i_Start = 1'b0;
    endtask

    // One-cycle start pulse with junk operands; the caller guarantees the DUT is not IDLE.
    task automatic junk_start();
        i_Op_A       = $urandom;
        i_Op_B       = $urandom;
        i_Op_C       = $urandom;
        i_Accumulate = 1'($urandom_range(0, 1));
        i_Start      = 1'b1;
        @(negedge i_CLK);
        i_Start = 1'b0;
    endtask

    initial begin
        int guard;
        logic [W-1:0] a, b, c;
        i_NRESET     = 1'b0;
        i_Start      = 1'b0;
        i_Accumulate = 1'b0;
        i_Op_A       = '0;
        i_Op_B       = '0;
        i_Op_C       = '0;

        // Reset state.
        #3;
        check("rst_busy", 64'(o_Busy), 64'(0));
        check("rst_done", 64'(o_Done), 64'(0));
        check("rst_req", 64'(o_ALU_Req), 64'(0));
        check("rst_result", 64'(o_Result), 64'(0));
        check("rst_flags", 64'(o_Flags), 64'(0));
        check("rst_alu_a", 64'(o_ALU_A), 64'(0));
        check("rst_alu_b", 64'(o_ALU_B), 64'(0));
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_NRESET = 1'b1;
        @(negedge i_CLK);

        // Directed cases; a start pulse while busy must be ignored.
        issue(32'd7, 32'd6, 32'd0, 1'b0);
        junk_start();
        issue(32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(32'd3, 32'd5, 32'h10, 1'b1);

        // Start asserted during DONE is ignored; start in the following cycle is accepted.
        guard = 0;
        while (!o_Done && guard < 100) begin
            @(negedge i_CLK);
            guard++;
        end
        check("wait_done", 64'(o_Done), 64'(1));
        junk_start();
        issue(32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0);

        // Reset asserted mid-multiply: asynchronous clear, no o_Done.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
        repeat (9) @(negedge i_CLK);
        #3;
        i_NRESET = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_busy", 64'(o_Busy), 64'(0));
        check("mid_rst_done", 64'(o_Done), 64'(0));
        check("mid_rst_req", 64'(o_ALU_Req), 64'(0));
        check("mid_rst_result", 64'(o_Result), 64'(0));
        check("mid_rst_flags", 64'(o_Flags), 64'(0));
        check("mid_rst_alu_a", 64'(o_ALU_A), 64'(0));
        check("mid_rst_alu_b", 64'(o_ALU_B), 64'(0));
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_NRESET = 1'b1;
        @(negedge i_CLK);
        issue(32'd2, 32'd2, 32'd0, 1'b0);

        // Randomized operations with random gaps, multiplier widths and stray starts.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = '0;
            c = $urandom;
            issue(a, b, c, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) junk_start();
            repeat ($urandom_range(0, 3)) @(negedge i_CLK);
        end

        // Drain outstanding expectations.
        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge i_CLK);
            guard++;
        end
        check("drain_outstanding", 64'(sb.size()), 64'(0));
        repeat (3) @(negedge i_CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
